// File: rtl/sockit_spi_axi_mst.sv
`default_nettype none
// ============================================================================
// Module   : sockit_spi_axi_mst
// Purpose  : AXI4-Lite master. Converts a valid/ready command stream into
//            single AXI4-Lite read or write transactions, one at a time, and
//            returns each result on a valid/ready response stream.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   AW   address width
//   DW   data width (32 or 64), strobe width DW/8
//   TMO  watchdog limit in clk cycles (only with SOCKIT_SPI_AXI_MST_TMO_EN)
// Ports
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   cmd_vld/cmd_rdy          command handshake, cmd_rdy high only in IDLE
//   cmd_wen/adr/wdt/ben      command: 1=write/0=read, address, data, byte enables
//   rsp_vld/rsp_rdy          response handshake
//   rsp_rdt/rsp_err          read data (0 for writes), BRESP/RRESP (2'b11 also
//                            reports a watchdog expiry)
//   axi_aw*/w*/b*/ar*/r*     AXI4-Lite master channels
// Configuration
//   SOCKIT_SPI_AXI_MST_TMO_EN  defined: build the bring-up watchdog that aborts a
//                              stalled transaction after TMO busy cycles.
//                              undefined: no counter, the FSM waits indefinitely.
// ============================================================================
module sockit_spi_axi_mst #(
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int TMO = 256
) (
  input  logic            clk,
  input  logic            rst,
  // command stream
  input  logic            cmd_vld,
  output logic            cmd_rdy,
  input  logic            cmd_wen,
  input  logic [AW-1:0]   cmd_adr,
  input  logic [DW-1:0]   cmd_wdt,
  input  logic [DW/8-1:0] cmd_ben,
  // response stream
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [DW-1:0]   rsp_rdt,
  output logic [1:0]      rsp_err,
  // AXI4-Lite write address
  output logic            axi_awvalid,
  input  logic            axi_awready,
  output logic [AW-1:0]   axi_awaddr,
  // AXI4-Lite write data
  output logic            axi_wvalid,
  input  logic            axi_wready,
  output logic [DW-1:0]   axi_wdata,
  output logic [DW/8-1:0] axi_wstrb,
  // AXI4-Lite write response
  input  logic            axi_bvalid,
  output logic            axi_bready,
  input  logic [1:0]      axi_bresp,
  // AXI4-Lite read address
  output logic            axi_arvalid,
  input  logic            axi_arready,
  output logic [AW-1:0]   axi_araddr,
  // AXI4-Lite read data
  input  logic            axi_rvalid,
  output logic            axi_rready,
  input  logic [DW-1:0]   axi_rdata,
  input  logic [1:0]      axi_rresp
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WADR = 3'd1,
    WRSP = 3'd2,
    RADR = 3'd3,
    RDAT = 3'd4,
    RSP  = 3'd5
  } state_t;

  state_t          state_q;

  // every output is a register; nothing reaches an output combinationally
  logic            cmd_rdy_q;
  logic            rsp_vld_q;
  logic [DW-1:0]   rsp_rdt_q;
  logic [1:0]      rsp_err_q;
  logic            awvalid_q;
  logic [AW-1:0]   awaddr_q;
  logic            wvalid_q;
  logic [DW-1:0]   wdata_q;
  logic [DW/8-1:0] wstrb_q;
  logic            bready_q;
  logic            arvalid_q;
  logic [AW-1:0]   araddr_q;
  logic            rready_q;

  // AW and W complete independently; a channel counts as done either when it
  // was already accepted earlier or when it is accepted in this cycle.
  logic            aw_ok;
  logic            w_ok;
  logic            leave;    // current AXI phase completes at this edge
  logic            busy;     // a bus phase is outstanding
  logic            tmo_hit;  // watchdog reaches its limit at this edge
  logic            expire;   // abort the transaction at this edge

  assign aw_ok = !awvalid_q || axi_awready;
  assign w_ok  = !wvalid_q  || axi_wready;

  assign busy  = (state_q == WADR) || (state_q == WRSP) ||
                 (state_q == RADR) || (state_q == RDAT);

  always_comb begin
    leave = 1'b0;
    case (state_q)
      WADR:    leave = aw_ok && w_ok;
      WRSP:    leave = axi_bvalid;
      RADR:    leave = axi_arready;
      RDAT:    leave = axi_rvalid;
      default: leave = 1'b0;
    endcase
  end

  // A genuine completion in the same cycle as the watchdog limit wins, so a
  // finished transaction is never reported as a timeout.
  assign expire = busy && tmo_hit && !leave;

`ifdef SOCKIT_SPI_AXI_MST_TMO_EN
  localparam int CW = $clog2(TMO + 1);

  logic [CW-1:0] tmo_q;

  // tmo_q holds the number of busy cycles already elapsed, so the limit is
  // hit during the TMO-th busy cycle.
  assign tmo_hit = (tmo_q == CW'(TMO - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q <= '0;
    end else if ((state_q == IDLE) && cmd_vld) begin
      tmo_q <= '0;
    end else if (busy && !tmo_hit) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end
`else
  logic unused_tmo;

  assign tmo_hit    = 1'b0;
  assign unused_tmo = (TMO != 0);
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      cmd_rdy_q <= 1'b1;
      rsp_vld_q <= 1'b0;
      rsp_rdt_q <= '0;
      rsp_err_q <= 2'b00;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      wvalid_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bready_q  <= 1'b0;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      rready_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_vld) begin
            cmd_rdy_q <= 1'b0;
            if (cmd_wen) begin
              awaddr_q  <= cmd_adr;
              wdata_q   <= cmd_wdt;
              wstrb_q   <= cmd_ben;
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= WADR;
            end else begin
              araddr_q  <= cmd_adr;
              arvalid_q <= 1'b1;
              state_q   <= RADR;
            end
          end
        end

        WADR: begin
          // each valid falls only on its own handshake; clearing an already
          // low valid is harmless
          if (axi_awready) begin
            awvalid_q <= 1'b0;
          end
          if (axi_wready) begin
            wvalid_q <= 1'b0;
          end
          if (aw_ok && w_ok) begin
            bready_q <= 1'b1;
            state_q  <= WRSP;
          end
        end

        WRSP: begin
          if (axi_bvalid) begin
            bready_q  <= 1'b0;
            rsp_rdt_q <= '0;
            rsp_err_q <= axi_bresp;
            rsp_vld_q <= 1'b1;
            state_q   <= RSP;
          end
        end

        RADR: begin
          if (axi_arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= RDAT;
          end
        end

        RDAT: begin
          if (axi_rvalid) begin
            rready_q  <= 1'b0;
            rsp_rdt_q <= axi_rdata;
            rsp_err_q <= axi_rresp;
            rsp_vld_q <= 1'b1;
            state_q   <= RSP;
          end
        end

        RSP: begin
          // cmd_rdy rises only after this edge, so the next command cannot be
          // taken in the response handshake cycle
          if (rsp_rdy) begin
            rsp_vld_q <= 1'b0;
            cmd_rdy_q <= 1'b1;
            state_q   <= IDLE;
          end
        end

        default: begin
          state_q   <= IDLE;
          cmd_rdy_q <= 1'b1;
        end
      endcase

      // Watchdog abort: drops every AXI valid/ready mid-transaction. This is
      // deliberately protocol-breaking and only meant for bring-up; any late
      // B/R beat is ignored because the ready is already low.
      if (expire) begin
        awvalid_q <= 1'b0;
        wvalid_q  <= 1'b0;
        bready_q  <= 1'b0;
        arvalid_q <= 1'b0;
        rready_q  <= 1'b0;
        rsp_rdt_q <= '0;
        rsp_err_q <= 2'b11;
        rsp_vld_q <= 1'b1;
        state_q   <= RSP;
      end
    end
  end

  assign cmd_rdy     = cmd_rdy_q;
  assign rsp_vld     = rsp_vld_q;
  assign rsp_rdt     = rsp_rdt_q;
  assign rsp_err     = rsp_err_q;
  assign axi_awvalid = awvalid_q;
  assign axi_awaddr  = awaddr_q;
  assign axi_wvalid  = wvalid_q;
  assign axi_wdata   = wdata_q;
  assign axi_wstrb   = wstrb_q;
  assign axi_bready  = bready_q;
  assign axi_arvalid = arvalid_q;
  assign axi_araddr  = araddr_q;
  assign axi_rready  = rready_q;

endmodule
`default_nettype wire
